// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Multi-channel pushbutton conditioner. Each channel has a
//                2-FF synchroniser, a stability-count debouncer, registered
//                level/rise/fall strobes and an auto-repeat press generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_COUNT  = 1024,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press
);

    localparam int DB_W    = $clog2(STABLE_COUNT + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W    = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0] c_DB_LAST     = DB_W'(STABLE_COUNT - 1);
    localparam logic [RP_W-1:0] c_DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] c_PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    // Repeat FSM state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HELD   = 2'd1;
    localparam logic [1:0] c_ST_DELAY  = 2'd2;
    localparam logic [1:0] c_ST_REPEAT = 2'd3;

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    // Two-stage synchroniser for all raw inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [DB_W-1:0] r_db_cnt;
            logic [RP_W-1:0] r_rp_cnt;
            logic [1:0]      r_state;
            logic            r_level;
            logic            r_rise;
            logic            r_fall;
            logic            r_press;
            logic            w_diff;
            logic            w_db_done;
            logic            w_up;
            logic            w_dn;

            // A flip happens on the edge where the input has disagreed with
            // the level for STABLE_COUNT consecutive synchronised samples.
            assign w_diff    = (r_sync2[i] != r_level);
            assign w_db_done = w_diff && (r_db_cnt == c_DB_LAST);
            assign w_up      = w_db_done &&  r_sync2[i];
            assign w_dn      = w_db_done && !r_sync2[i];

            // Debounce counter and debounced level
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_db_cnt <= '0;
                    r_level  <= 1'b0;
                end else if (!w_diff) begin
                    r_db_cnt <= '0;
                end else if (w_db_done) begin
                    r_db_cnt <= '0;
                    r_level  <= r_sync2[i];
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            // Edge strobes and auto-repeat press generator; a fall always
            // wins over a repeat that would fire on the same edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state  <= c_ST_IDLE;
                    r_rp_cnt <= '0;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                    r_press  <= 1'b0;
                end else begin
                    r_rise  <= w_up;
                    r_fall  <= w_dn;
                    r_press <= 1'b0;
                    if (w_dn) begin
                        r_state  <= c_ST_IDLE;
                        r_rp_cnt <= '0;
                    end else if (w_up) begin
                        r_press  <= 1'b1;
                        r_rp_cnt <= '0;
                        r_state  <= repeat_en[i] ? c_ST_DELAY : c_ST_HELD;
                    end else begin
                        case (r_state)
                            c_ST_HELD: begin
                                if (repeat_en[i]) begin
                                    r_rp_cnt <= '0;
                                    r_state  <= c_ST_DELAY;
                                end
                            end
                            c_ST_DELAY: begin
                                if (!repeat_en[i]) begin
                                    r_rp_cnt <= '0;
                                    r_state  <= c_ST_HELD;
                                end else if (r_rp_cnt == c_DELAY_LAST) begin
                                    r_press  <= 1'b1;
                                    r_rp_cnt <= '0;
                                    r_state  <= c_ST_REPEAT;
                                end else begin
                                    r_rp_cnt <= r_rp_cnt + 1'b1;
                                end
                            end
                            c_ST_REPEAT: begin
                                if (!repeat_en[i]) begin
                                    r_rp_cnt <= '0;
                                    r_state  <= c_ST_HELD;
                                end else if (r_rp_cnt == c_PERIOD_LAST) begin
                                    r_press  <= 1'b1;
                                    r_rp_cnt <= '0;
                                end else begin
                                    r_rp_cnt <= r_rp_cnt + 1'b1;
                                end
                            end
                            default: begin
                                r_rp_cnt <= '0;
                            end
                        endcase
                    end
                end
            end

            assign level[i] = r_level;
            assign rise[i]  = r_rise;
            assign fall[i]  = r_fall;
            assign press[i] = r_press;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner with
//                STABLE_COUNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, 2 channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int CH = 2;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] raw_in = '0;
    logic [CH-1:0] repeat_en = '0;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] press;

    button_conditioner #(
        .CHANNELS      (CH),
        .STABLE_COUNT  (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .repeat_en (repeat_en),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .press     (press)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge N has completed, cyc == N
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorders (sampled mid-cycle)
    int p0[$];
    int p1[$];
    int f0[$];
    int f1[$];
    bit overlap = 1'b0;
    always @(negedge clk) begin
        if (press[0]) p0.push_back(cyc);
        if (press[1]) p1.push_back(cyc);
        if (fall[0])  f0.push_back(cyc);
        if (fall[1])  f1.push_back(cyc);
        if (|(rise & fall)) overlap = 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;
    int t;
    int c;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        p0.delete();
        p1.delete();
        f0.delete();
        f1.delete();
    endtask

    task automatic wait_rise(input int ch, output int tr);
        tr = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rise[ch]) begin
                tr = cyc;
                break;
            end
        end
        if (tr < 0) check("rise_timeout", 0, 1);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(3);
        check("rst_level", int'(level), 0);
        check("rst_rise",  int'(rise),  0);
        check("rst_fall",  int'(fall),  0);
        check("rst_press", int'(press), 0);
        #2 rst = 1'b0;

        // Basic press: exact debounce latency, one-cycle strobes
        tick(1);
        clear_q();
        raw_in = 2'b01;
        tick(5);
        check("lat_level_early", int'(level[0]), 0);
        tick(1);
        check("lat_level", int'(level[0]), 1);
        check("lat_rise",  int'(rise[0]),  1);
        check("lat_press", int'(press[0]), 1);
        check("lat_fall",  int'(fall[0]),  0);
        check("lat_ch1",   int'(level[1]), 0);
        tick(1);
        check("lat_rise_1cyc",  int'(rise[0]),  0);
        check("lat_press_1cyc", int'(press[0]), 0);
        tick(20);
        check("held_no_repeat", p0.size(), 1);
        raw_in = 2'b00;
        tick(6);
        check("rel_fall",  int'(fall[0]),  1);
        check("rel_level", int'(level[0]), 0);
        tick(2);

        // Glitch of 3 cycles is rejected
        clear_q();
        raw_in = 2'b01;
        tick(3);
        raw_in = 2'b00;
        tick(10);
        check("glitch_press", p0.size(), 0);
        check("glitch_level", int'(level[0]), 0);

        // Release bounce yields a single, late fall
        raw_in = 2'b01;
        wait_rise(0, t);
        tick(2);
        clear_q();
        raw_in = 2'b00; tick(2);
        raw_in = 2'b01; tick(2);
        raw_in = 2'b00; tick(2);
        raw_in = 2'b01; tick(2);
        raw_in = 2'b00;
        c = cyc;
        tick(10);
        check("bounce_nfall", f0.size(), 1);
        check("bounce_fall_t", qat(f0, 0), c + 6);

        // Auto-repeat; fall coincides with a due repeat and suppresses it
        repeat_en = 2'b01;
        clear_q();
        raw_in = 2'b01;
        wait_rise(0, t);
        tick(13);
        raw_in = 2'b00;
        tick(20);
        check("rpt_npress", p0.size(), 4);
        check("rpt_p0", qat(p0, 0), t);
        check("rpt_p1", qat(p0, 1), t + 10);
        check("rpt_p2", qat(p0, 2), t + 13);
        check("rpt_p3", qat(p0, 3), t + 16);
        check("rpt_fall_t", qat(f0, 0), t + 19);

        // repeat_en dropped after t+13, reasserted at t+20
        clear_q();
        raw_in = 2'b01;
        wait_rise(0, t);
        tick(13);
        repeat_en = 2'b00;
        tick(6);
        repeat_en = 2'b01;
        tick(10);
        raw_in = 2'b00;
        tick(15);
        check("en_npress", p0.size(), 5);
        check("en_p2", qat(p0, 2), t + 13);
        check("en_p3", qat(p0, 3), t + 30);
        check("en_p4", qat(p0, 4), t + 33);
        check("en_fall_t", qat(f0, 0), t + 35);

        // Reset mid-REPEAT with button held
        clear_q();
        raw_in = 2'b01;
        wait_rise(0, t);
        tick(15);
        rst = 1'b1;
        #1;
        check("mid_rst_level", int'(level), 0);
        check("mid_rst_press", int'(press), 0);
        check("mid_rst_rise",  int'(rise),  0);
        tick(2);
        clear_q();
        rst = 1'b0;
        c = cyc;
        tick(20);
        check("post_rst_p0", qat(p0, 0), c + 6);
        check("post_rst_p1", qat(p0, 1), c + 16);
        check("post_rst_p2", qat(p0, 2), c + 19);
        raw_in = 2'b00;
        tick(12);

        // Two channels pressed together, released at different times
        repeat_en = 2'b11;
        clear_q();
        raw_in = 2'b11;
        wait_rise(0, t);
        check("dual_rise1", int'(rise[1]), 1);
        tick(3);
        raw_in = 2'b01;
        tick(8);
        raw_in = 2'b00;
        tick(12);
        check("dual_ch1_npress", p1.size(), 1);
        check("dual_ch1_p0", qat(p1, 0), t);
        check("dual_ch1_fall", qat(f1, 0), t + 9);
        check("dual_ch0_npress", p0.size(), 4);
        check("dual_ch0_p1", qat(p0, 1), t + 10);
        check("dual_ch0_p3", qat(p0, 3), t + 16);
        check("dual_ch0_fall", qat(f0, 0), t + 17);

        check("rise_fall_excl", int'(overlap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
